psi_pow_gen: RTL and testbench
==============================

PSI_POW_GEN -- requirements
Module: psi_pow_gen

Interface
REQ-001 SHALL have parameter Q, default 257: modulus; only the default is verified.
REQ-002 SHALL have parameter W, default 9: coefficient width.
REQ-003 SHALL have parameter AW, default 3: table address width, giving 8 entries.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  request generation from psi_in.
REQ-007 SHALL have port psi_in  input  W  root of unity psi, sampled only when start is accepted.
REQ-008 SHALL have port busy  output  1  generation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when generation completes.
REQ-010 SHALL have port ready  output  1  table contents valid.
REQ-011 SHALL have port err  output  1  one-cycle pulse when start is rejected.
REQ-012 SHALL have port rd_en  input  1  read request.
REQ-013 SHALL have port rd_addr  input  AW  read address.
REQ-014 SHALL have port rd_data  output  W  forward entry psi^brv(rd_addr) mod Q.
REQ-015 SHALL have port rd_valid  output  1  rd_data (and rd_data_inv) valid this cycle.
REQ-016 SHALL have port rd_data_inv  output  W  inverse entry psi^-brv(rd_addr) mod Q; present only with PSI_GEN_INV_EN.

Function
REQ-017 SHALL implement FSM states IDLE and GEN; reset state is IDLE.
REQ-018 SHALL accept start only in IDLE with psi_in < Q; on acceptance: acc=1, k=0, ready=0, busy=1, go to GEN.
REQ-019 SHALL, in IDLE with start=1 and psi_in >= Q, pulse err for one cycle and change no other state.
REQ-020 SHALL ignore start while in GEN: no restart, no err.
REQ-021 SHALL, each GEN cycle, write acc to fwd[brv(k)] when k<8, update acc = (acc*psi) mod Q using the full 2W-bit product, and increment k.
REQ-022 SHALL define brv as 3-bit bit reversal, e.g. brv(1)=4 and brv(3)=6.
REQ-023 SHALL run GEN for K cycles (K=8 without the macro, K=16 with it), then return to IDLE with busy=0, ready=1, and done=1 for exactly one cycle.
REQ-024 SHALL assert done K+1 cycles after the edge at which start is accepted.
REQ-025 SHALL, on rd_en=1 with ready=1, register rd_data=fwd[rd_addr] and rd_valid=1 on the next cycle: one-cycle latency, back-to-back reads allowed.
REQ-026 SHALL, on rd_en=1 with ready=0 or rd_en=0, drive rd_valid=0 next cycle while rd_data holds its last value.
REQ-027 SHALL allow a start accepted in the same cycle as a rd_en; that read completes, and reads issued after acceptance return rd_valid=0.

Reset
REQ-028 SHALL, on rst_n=0 (including mid-GEN), immediately force IDLE, acc=1, k=0, all table entries=0, and busy, done, ready, err, rd_valid, rd_data, rd_data_inv=0.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deasserts, without a fresh start being needed for reset to complete.

Configuration
REQ-030 SHALL, when PSI_GEN_INV_EN is defined, build an 8-entry inverse table: inv[0] written at k=0, and inv[brv(16-k)] written at k=9..15, so that inv[brv(j)] = psi^(16-j); K=16.
REQ-031 SHALL register rd_data_inv alongside rd_data under the same read rules when PSI_GEN_INV_EN is defined.
REQ-032 SHALL, when PSI_GEN_INV_EN is undefined, omit the rd_data_inv port and the inverse table, with K=8.

Verification
REQ-033 SHALL cover: reset, start with psi_in=2 -> done 9 cycles later; reading addr 0..7 returns 1, 16, 4, 64, 2, 32, 8, 128.
REQ-034 SHALL cover, with PSI_GEN_INV_EN defined: psi_in=2 -> done 17 cycles after acceptance; rd_data_inv for addr 0..7 returns 1, 241, 193, 253, 129, 249, 225, 255.
REQ-035 SHALL cover: start with psi_in=300 -> err pulses for 1 cycle, busy stays 0, ready unchanged.
REQ-036 SHALL cover: rd_en with addr 5 before any generation -> rd_valid=0, rd_data=0; start pulsed again during GEN -> ignored, done fires once.
REQ-037 SHALL cover: rst_n asserted at GEN cycle 4, then release and read addr 0 -> ready=0, rd_valid=0; a new start with psi_in=2 then yields the REQ-033 values.
REQ-038 SHALL cover: 8 back-to-back rd_en cycles after ready -> rd_valid high for 8 consecutive cycles with correct data, one cycle after each request.

Source files
------------

// File: rtl/psi_pow_gen.sv
// ---------------------------------------------------------------------------
// psi_pow_gen -- twiddle-factor table generator for a small NTT.
//
// Given a root of unity psi (mod Q), fills an 8-entry table so that
// fwd[a] = psi^brv(a) mod Q, where brv is AW-bit bit reversal. The table is
// built one power per cycle by repeated modular multiplication. Each read
// returns its result one cycle after the request.
//
// Optional feature (macro PSI_GEN_INV_EN):
//   When defined, generation runs 16 powers instead of 8. The extra powers
//   fill an inverse table so that inv[brv(j)] = psi^(16-j), with inv[0] = 1.
//   A second read port, rd_data_inv, is added.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, psi_in  generation request and its root (must be < Q)
//   busy           generation in progress
//   done           one-cycle pulse when generation completes
//   ready          table contents valid
//   err            one-cycle pulse when a start is rejected (psi_in >= Q)
//   rd_en, rd_addr read request and address
//   rd_data        forward table entry, one cycle after rd_en
//   rd_valid       rd_data (and rd_data_inv) valid this cycle
//   rd_data_inv    inverse table entry (PSI_GEN_INV_EN only)
// ---------------------------------------------------------------------------
module psi_pow_gen #(
    parameter int Q  = 257,
    parameter int W  = 9,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  psi_in,
    output logic          busy,
    output logic          done,
    output logic          ready,
    output logic          err,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid
`ifdef PSI_GEN_INV_EN
    ,
    output logic [W-1:0]  rd_data_inv
`endif
);

    localparam int N = 1 << AW;
`ifdef PSI_GEN_INV_EN
    localparam int K = 2 * N;
`else
    localparam int K = N;
`endif
    localparam int KW = $clog2(K + 1);

    localparam logic [KW-1:0]  K_LAST = KW'(K);
    localparam logic [KW-1:0]  N_K    = KW'(N);
    localparam logic [W:0]     Q_CMP  = (W + 1)'(Q);
    localparam logic [2*W-1:0] Q_MOD  = (2 * W)'(Q);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // AW-bit bit reversal of a table index.
    function automatic logic [AW-1:0] brv(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic           accept_s;
    logic           reject_s;
    logic           last_s;
    logic           psi_ok_s;
    logic [W-1:0]   acc_r;
    logic [W-1:0]   psi_r;
    logic [KW-1:0]  k_r;
    logic [W-1:0]   fwd_r [N];
    logic [2*W-1:0] prod_s;
    logic [2*W-1:0] rem_s;
    logic           busy_r;
    logic           done_r;
    logic           ready_r;
    logic           err_r;
    logic           rd_valid_r;
    logic [W-1:0]   rd_data_r;
`ifdef PSI_GEN_INV_EN
    logic [W-1:0]   inv_r [N];
    logic [W-1:0]   rd_data_inv_r;
    logic [AW-1:0]  inv_idx_s;
`endif

    // Modular multiply on the full 2W-bit product.
    always_comb begin
        prod_s = (2 * W)'(acc_r) * (2 * W)'(psi_r);
        rem_s  = prod_s % Q_MOD;
    end

    // Range check of the incoming root.
    always_comb begin
        psi_ok_s = ({1'b0, psi_in} < Q_CMP);
    end

`ifdef PSI_GEN_INV_EN
    // Inverse-table slot for power k: brv(2N - k), low AW bits only.
    always_comb begin
        inv_idx_s = brv(AW'(K_LAST - k_r));
    end
`endif

    // FSM next-state and strobes; the last GEN cycle (k == K) only finalises.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (psi_ok_s) begin
                        accept_s    = 1'b1;
                        state_nxt_s = GEN;
                    end else begin
                        reject_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GEN: begin
                if (k_r == K_LAST) begin
                    last_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GEN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Power accumulator, table writes and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= W'(1);
            psi_r   <= '0;
            k_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                fwd_r[i] <= '0;
`ifdef PSI_GEN_INV_EN
                inv_r[i] <= '0;
`endif
            end
        end else begin
            done_r <= last_s;
            err_r  <= reject_s;
            if (accept_s) begin
                acc_r   <= W'(1);
                k_r     <= '0;
                psi_r   <= psi_in;
                ready_r <= 1'b0;
                busy_r  <= 1'b1;
            end else if (last_s) begin
                busy_r  <= 1'b0;
                ready_r <= 1'b1;
            end else if (state_r == GEN) begin
                if (k_r < N_K) begin
                    fwd_r[brv(AW'(k_r))] <= acc_r;
                end else begin
                    fwd_r[0] <= fwd_r[0];
                end
`ifdef PSI_GEN_INV_EN
                // inv[0] takes psi^0; powers N+1..2N-1 land mirrored.
                if (k_r == '0) begin
                    inv_r[0] <= acc_r;
                end else if (k_r > N_K) begin
                    inv_r[inv_idx_s] <= acc_r;
                end else begin
                    inv_r[0] <= inv_r[0];
                end
`endif
                acc_r <= W'(rem_s);
                k_r   <= k_r + KW'(1);
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Read port: one-cycle latency, data held when no valid read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
`ifdef PSI_GEN_INV_EN
            rd_data_inv_r <= '0;
`endif
        end else begin
            if (rd_en && ready_r) begin
                rd_valid_r <= 1'b1;
                rd_data_r  <= fwd_r[rd_addr];
`ifdef PSI_GEN_INV_EN
                rd_data_inv_r <= inv_r[rd_addr];
`endif
            end else begin
                rd_valid_r <= 1'b0;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign ready    = ready_r;
    assign err      = err_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
`ifdef PSI_GEN_INV_EN
    assign rd_data_inv = rd_data_inv_r;
`endif

endmodule

// File: tb/tb_psi_pow_gen.sv
// ---------------------------------------------------------------------------
// tb_psi_pow_gen -- self-checking bench for psi_pow_gen.
// Expected table values are computed from powers of psi mod Q using plain
// arithmetic. Directed steps cover reset, latency, rejection, ignored
// restarts, mid-generation reset and back-to-back reads, followed by
// randomised roots.
// ---------------------------------------------------------------------------
module tb_psi_pow_gen;

    localparam int Q  = 257;
    localparam int W  = 9;
    localparam int AW = 3;
`ifdef PSI_GEN_INV_EN
    localparam int K = 16;
`else
    localparam int K = 8;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  psi_in = '0;
    logic          busy, done, ready, err;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
`ifdef PSI_GEN_INV_EN
    logic [W-1:0]  rd_data_inv;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    psi_pow_gen #(.Q(Q), .W(W), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .psi_in   (psi_in),
        .busy     (busy),
        .done     (done),
        .ready    (ready),
        .err      (err),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
`ifdef PSI_GEN_INV_EN
        ,
        .rd_data_inv (rd_data_inv)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: bit reversal of a 3-bit index by arithmetic.
    function automatic int rev3(input int a);
        int r = 0;
        for (int i = 0; i < 3; i++) begin
            r = r * 2 + ((a >> i) % 2);
        end
        return r;
    endfunction

    function automatic int powmod(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    function automatic int exp_fwd(input int psi, input int a);
        return powmod(psi, rev3(a));
    endfunction

    function automatic int exp_inv(input int psi, input int a);
        int e = rev3(a);
        return (e == 0) ? 1 : powmod(psi, 16 - e);
    endfunction

    // Accept a start, optionally poke start mid-run, and time done.
    task automatic gen(input int psi, input bit poke);
        int first_done = -1;
        int n_done = 0;
        start  = 1'b1;
        psi_in = W'(psi);
        tick();
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", ready, 0);
        for (int c = 1; c <= K + 8; c++) begin
            if (poke && c == 3) begin
                start  = 1'b1;
                psi_in = W'(5);
            end
            tick();
            if (poke && c == 3) start = 1'b0;
            if (poke && c == 4) chk("err_on_restart", err, 0);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
        end
        chk("done_latency", first_done, K + 1);
        chk("done_count", n_done, 1);
        chk("busy_end", busy, 0);
        chk("ready_end", ready, 1);
    endtask

    // Eight back-to-back reads in order, then a hold check.
    task automatic read_all(input int psi);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = AW'(i);
            tick();
            chk($sformatf("rd_valid_%0d", i), rd_valid, 1);
            chk($sformatf("rd_data_%0d", i), rd_data, exp_fwd(psi, i));
`ifdef PSI_GEN_INV_EN
            chk($sformatf("rd_inv_%0d", i), rd_data_inv, exp_inv(psi, i));
`endif
        end
        rd_en = 1'b0;
        tick();
        chk("rd_valid_idle", rd_valid, 0);
        chk("rd_data_hold", rd_data, exp_fwd(psi, 7));
    endtask

    initial begin
        int psi;
        int a;
        // Reset state.
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Read before any generation.
        rd_en   = 1'b1;
        rd_addr = AW'(5);
        tick();
        rd_en = 1'b0;
        chk("early_rd_valid", rd_valid, 0);
        chk("early_rd_data", rd_data, 0);

        // Known root psi = 2.
        gen(2, 1'b0);
        read_all(2);

        // Out-of-range root.
        start  = 1'b1;
        psi_in = W'(300);
        tick();
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_ready", ready, 1);
        tick();
        chk("err_one_cycle", err, 0);
        chk("err_busy2", busy, 0);

        // Restart attempt during generation is ignored.
        gen(3, 1'b1);
        read_all(3);

        // Read in the accepting cycle completes; later reads do not.
        rd_en   = 1'b1;
        rd_addr = AW'(3);
        start   = 1'b1;
        psi_in  = W'(2);
        tick();
        start = 1'b0;
        chk("acc_rd_valid", rd_valid, 1);
        chk("acc_rd_data", rd_data, exp_fwd(3, 3));
        chk("acc_busy", busy, 1);
        tick();
        rd_en = 1'b0;
        chk("acc_rd_after", rd_valid, 0);
        for (int c = 0; c < K + 4; c++) tick();
        chk("acc_ready", ready, 1);
        read_all(2);

        // Reset in the middle of generation.
        start  = 1'b1;
        psi_in = W'(7);
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ready, 0);
        tick();
        rst_n = 1'b1;
        rd_en   = 1'b1;
        rd_addr = AW'(0);
        tick();
        rd_en = 1'b0;
        chk("post_rst_rd_valid", rd_valid, 0);
        chk("post_rst_ready", ready, 0);
        chk("post_rst_rd_data", rd_data, 0);
        gen(2, 1'b0);
        read_all(2);

        // Randomised roots with random-order reads.
        for (int t = 0; t < 4; t++) begin
            psi = int'($urandom_range(0, Q - 1));
            gen(psi, 1'b0);
            rd_en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                a = int'($urandom_range(0, 7));
                rd_addr = AW'(a);
                tick();
                chk("rnd_rd_valid", rd_valid, 1);
                chk($sformatf("rnd_rd_data_psi%0d_a%0d", psi, a), rd_data, exp_fwd(psi, a));
`ifdef PSI_GEN_INV_EN
                chk($sformatf("rnd_rd_inv_psi%0d_a%0d", psi, a), rd_data_inv, exp_inv(psi, a));
`endif
            end
            rd_en = 1'b0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
